// File: rtl/prio.sv
// Display-source priority selector: registers the most advanced ready stage
// (product, then second operand, then first operand) onto the 16-bit display bus.
module prio (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  num_1,
  input  logic [7:0]  num_2,
  input  logic        listo_1,
  input  logic        listo_2,
  input  logic        listo,
  input  logic [15:0] num_mul,
  output logic [15:0] numero_output
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_OP1  = 2'd1,
    SEL_OP2  = 2'd2,
    SEL_MUL  = 2'd3
  } sel_e;

  sel_e        sel_d, sel_q;
  logic [15:0] out_d, out_q;
  logic        load;

  // Fixed priority: product beats second operand beats first operand.
  always_comb begin
    sel_d = SEL_NONE;
    if (listo) begin
      sel_d = SEL_MUL;
    end else if (listo_2) begin
      sel_d = SEL_OP2;
    end else if (listo_1) begin
      sel_d = SEL_OP1;
    end
  end

  always_comb begin
    out_d = 16'h0000;
    unique case (sel_d)
      SEL_MUL:  out_d = num_mul;
      SEL_OP2:  out_d = {8'h00, num_2};
      SEL_OP1:  out_d = {8'h00, num_1};
      SEL_NONE: out_d = 16'h0000;
      default:  out_d = 16'h0000;
    endcase
  end

  // Staying in NONE needs no reload: the output already holds zero there.
  assign load = !((sel_d == SEL_NONE) && (sel_q == SEL_NONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_NONE;
      out_q <= 16'h0000;
    end else begin
      sel_q <= sel_d;
      if (load) begin
        out_q <= out_d;
      end
    end
  end

  assign numero_output = out_q;

endmodule

// File: tb/tb_prio.sv
// Directed self-checking bench for prio: reset, staged priority, zero-extension,
// data tracking and mid-operation reset, with hand-computed expected values.
module tb_prio;

  logic        clk;
  logic        rst;
  logic [7:0]  num_1;
  logic [7:0]  num_2;
  logic        listo_1;
  logic        listo_2;
  logic        listo;
  logic [15:0] num_mul;
  logic [15:0] numero_output;

  int checks;
  int failures;

  prio dut (
    .clk          (clk),
    .rst          (rst),
    .num_1        (num_1),
    .num_2        (num_2),
    .listo_1      (listo_1),
    .listo_2      (listo_2),
    .listo        (listo),
    .num_mul      (num_mul),
    .numero_output(numero_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a full input vector away from the rising edge, then let one edge pass.
  task automatic applyStimulus(input logic r, input logic l1, input logic l2,
                               input logic l, input logic [7:0] n1,
                               input logic [7:0] n2, input logic [15:0] nm);
    @(negedge clk);
    rst     = r;
    listo_1 = l1;
    listo_2 = l2;
    listo   = l;
    num_1   = n1;
    num_2   = n2;
    num_mul = nm;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expected);
    checks++;
    assert (numero_output === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, numero_output, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    listo_1  = 1'b0;
    listo_2  = 1'b0;
    listo    = 1'b0;
    num_1    = 8'h00;
    num_2    = 8'h00;
    num_mul  = 16'h0000;

    // Reset with arbitrary inputs, including every flag set
    applyStimulus(1, 1, 1, 1, 8'h5A, 8'hC3, 16'hBEEF);
    checkOutput("reset_arbitrary", 16'h0000);
    applyStimulus(0, 0, 0, 0, 8'h5A, 8'hC3, 16'hBEEF);
    checkOutput("after_reset_noflags", 16'h0000);

    // Staged sequence
    applyStimulus(0, 0, 0, 0, 8'd15, 8'd10, 16'd150);
    checkOutput("staged_none", 16'h0000);
    applyStimulus(0, 1, 0, 0, 8'd15, 8'd10, 16'd150);
    checkOutput("staged_op1", 16'd15);
    applyStimulus(0, 1, 1, 0, 8'd15, 8'd10, 16'd150);
    checkOutput("staged_op2", 16'd10);
    applyStimulus(0, 1, 1, 1, 8'd15, 8'd10, 16'd150);
    checkOutput("staged_mul", 16'd150);
    applyStimulus(0, 1, 1, 1, 8'd15, 8'd10, 16'd150);
    checkOutput("staged_mul_hold", 16'd150);

    // Dropping every flag falls straight back to zero
    applyStimulus(0, 0, 0, 0, 8'd15, 8'd10, 16'd150);
    checkOutput("drop_all", 16'h0000);

    // All flags asserted in the same cycle, then peel off from the top
    applyStimulus(0, 1, 1, 1, 8'd15, 8'hAA, 16'hFFFF);
    checkOutput("prio_all_mul", 16'hFFFF);
    applyStimulus(0, 1, 1, 0, 8'd15, 8'hAA, 16'hFFFF);
    checkOutput("prio_drop_mul", 16'h00AA);
    applyStimulus(0, 1, 0, 0, 8'd15, 8'hAA, 16'hFFFF);
    checkOutput("prio_drop_op2", 16'h000F);

    // Zero-extension of the first operand
    applyStimulus(0, 1, 0, 0, 8'hFF, 8'hAA, 16'hFFFF);
    checkOutput("zext_op1", 16'h00FF);

    // Second operand selected; a change on num_1 must not leak through
    applyStimulus(0, 1, 1, 0, 8'h33, 8'h81, 16'hFFFF);
    checkOutput("op2_ignores_op1", 16'h0081);

    // Tracking the product; changes on unselected inputs are ignored
    applyStimulus(0, 0, 0, 1, 8'hFF, 8'hAA, 16'd150);
    checkOutput("track_mul_150", 16'd150);
    applyStimulus(0, 0, 0, 1, 8'hFF, 8'hAA, 16'd300);
    checkOutput("track_mul_300", 16'd300);
    applyStimulus(0, 0, 0, 1, 8'h12, 8'h34, 16'd300);
    checkOutput("track_unselected", 16'd300);

    // Mid-operation reset while the product is selected
    applyStimulus(0, 0, 0, 1, 8'h12, 8'h34, 16'd150);
    checkOutput("midreset_pre", 16'd150);
    applyStimulus(1, 0, 0, 1, 8'h12, 8'h34, 16'd150);
    checkOutput("midreset_asserted", 16'h0000);
    applyStimulus(0, 0, 0, 1, 8'h12, 8'h34, 16'd150);
    checkOutput("midreset_released", 16'd150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
